// File: rtl/ch_pkt_parser.sv
// rtl/ch_pkt_parser.sv - cluster-head announcement / heartbeat packet parser
// Optional own-ID filtering of announcements is enabled by defining SELF_FILTER_EN.
module ch_pkt_parser (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] node_ID,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] fCH_ID,
  output logic [15:0] fCH_Hops,
  output logic [15:0] fCH_QValue,
  output logic        en_KCH,
  output logic        HB_reset,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CH_ID   = 3'd1,
    S_CH_HOPS = 3'd2,
    S_CH_QV   = 3'd3,
    S_EMIT    = 3'd4,
    S_SKIP    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_skip_cnt;
  logic [15:0] r_ch_id;
  logic [15:0] r_ch_hops;
  logic [15:0] r_ch_qv;
  logic        r_en_kch;
  logic        r_hb_reset;
  logic [7:0]  r_drop_cnt;
  logic [15:0] r_fch_id;
  logic [15:0] r_fch_hops;
  logic [15:0] r_fch_qv;

  logic        w_accept;
  logic [3:0]  w_type;
  logic [7:0]  w_len;
  logic        w_is_ch;
  logic        w_is_hb;
  logic        w_filtered;
  logic        w_emit_ok;
  logic        w_drop_inc;
  logic        w_hb_set;
  logic        w_skip_load;
  logic [15:0] w_hops_inc;

  assign w_accept   = in_valid && in_ready;
  assign w_type     = in_data[15:12];
  // A zero length field still means the header occupies one word.
  assign w_len      = (in_data[7:0] == 8'd0) ? 8'd1 : in_data[7:0];
  assign w_is_ch    = (w_type == 4'h3);
  assign w_is_hb    = (w_type == 4'h1);
  assign w_hops_inc = (in_data == 16'hFFFF) ? 16'hFFFF : in_data + 16'd1;

`ifdef SELF_FILTER_EN
  assign w_filtered = (r_ch_id == node_ID);
`else
  assign w_filtered = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_ch && w_len == 8'd4) w_next = S_CH_ID;
          else if (w_len > 8'd1)        w_next = S_SKIP;
          else                          w_next = S_IDLE;
        end
      end
      S_CH_ID:   if (w_accept) w_next = S_CH_HOPS;
      S_CH_HOPS: if (w_accept) w_next = S_CH_QV;
      S_CH_QV:   if (w_accept) w_next = S_EMIT;
      S_EMIT:    w_next = S_IDLE;
      S_SKIP:    if (w_accept && r_skip_cnt <= 8'd1) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready    = !nrst || (r_state != S_EMIT);
    w_hb_set    = 1'b0;
    w_skip_load = 1'b0;
    w_emit_ok   = 1'b0;
    w_drop_inc  = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_hb_set    = w_is_hb;
          w_skip_load = !(w_is_ch && w_len == 8'd4) && (w_len > 8'd1);
          w_drop_inc  = w_is_ch && (w_len != 8'd4);
        end
        S_CH_QV: begin
          w_emit_ok  = !w_filtered;
          w_drop_inc = w_filtered;
        end
        default: ;
      endcase
    end
  end

  // Announcement fields are published on the Q-value edge so they are valid
  // in the same EMIT cycle that raises en_KCH.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_skip_cnt <= 8'd0;
      r_ch_id    <= 16'h0;
      r_ch_hops  <= 16'h0;
      r_ch_qv    <= 16'h0;
      r_en_kch   <= 1'b0;
      r_hb_reset <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_fch_id   <= 16'h0;
      r_fch_hops <= 16'hFFFF;
      r_fch_qv   <= 16'h0;
    end else begin
      r_en_kch   <= w_emit_ok;
      r_hb_reset <= w_hb_set;
      if (w_skip_load)
        r_skip_cnt <= w_len - 8'd1;
      else if (r_state == S_SKIP && w_accept)
        r_skip_cnt <= r_skip_cnt - 8'd1;
      if (r_state == S_CH_ID && w_accept)   r_ch_id   <= in_data;
      if (r_state == S_CH_HOPS && w_accept) r_ch_hops <= w_hops_inc;
      if (r_state == S_CH_QV && w_accept)   r_ch_qv   <= in_data;
      if (w_drop_inc && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_emit_ok) begin
        r_fch_id   <= r_ch_id;
        r_fch_hops <= r_ch_hops;
        r_fch_qv   <= in_data;
      end
    end
  end

  assign en_KCH     = r_en_kch;
  assign HB_reset   = r_hb_reset;
  assign drop_cnt   = r_drop_cnt;
  assign fCH_ID     = r_fch_id;
  assign fCH_Hops   = r_fch_hops;
  assign fCH_QValue = r_fch_qv;

endmodule
